// File: rtl/dfilter_mc.sv
// dfilter_mc: multi-channel debounce / majority filter with hysteresis.
// A shared prescaler produces a sample strobe (tick). On each tick every
// channel shifts its input into a DEPTH-sample window, keeps a running count
// of ones, and moves its output only when that count crosses HI_TH / LO_TH.
// rise/fall are registered single-cycle pulses marking output transitions.
// Build option: define DFILTER_SYNC_EN to pass each input bit through a
// 2-flop synchronizer before sampling (adds 2 clk of latency).
module dfilter_mc #(
    parameter int CH    = 4,
    parameter int DIV   = 447,
    parameter int DEPTH = 7,
    parameter int HI_TH = 6,
    parameter int LO_TH = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [CH-1:0] indata,
    output logic [CH-1:0] out,
    output logic [CH-1:0] rise,
    output logic [CH-1:0] fall,
    output logic          tick
);

    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [CW-1:0] HI_N     = CW'(HI_TH);
    localparam logic [CW-1:0] LO_N     = CW'(LO_TH);

    logic [DW-1:0]    div_cnt_q, div_cnt_d;
    logic             tick_raw;
    logic [CH-1:0]    s;

    logic [DEPTH-1:0] win_q [CH];
    logic [DEPTH-1:0] win_d [CH];
    logic [CW-1:0]    cnt_q [CH];
    logic [CW-1:0]    cnt_d [CH];
    logic [CH-1:0]    out_q, out_d;
    logic [CH-1:0]    rise_q, fall_q;

    // Prescaler terminal count; with DIV=1 the counter stays at 0 and ticks every cycle.
    assign tick_raw = (div_cnt_q == DIV_LAST);
    // tick is forced low while rst is held so downstream logic never sees a strobe in reset.
    assign tick     = tick_raw & ~rst;

    // Prescaler next value: wrap to 0 after DIV-1.
    always_comb begin
        div_cnt_d = div_cnt_q + DW'(1);
        if (tick_raw) begin
            div_cnt_d = '0;
        end
    end

`ifdef DFILTER_SYNC_EN
    logic [CH-1:0] sync1_q, sync2_q;

    // Two-flop synchronizer for inputs of asynchronous origin.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= indata;
            sync2_q <= sync1_q;
        end
    end

    assign s = sync2_q;
`else
    assign s = indata;
`endif

    // Per-channel window shift, incremental ones count and hysteresis decision.
    // The count update adds the new sample and drops the one leaving the window,
    // so it always stays within 0..DEPTH.
    always_comb begin
        out_d = out_q;
        for (int i = 0; i < CH; i++) begin
            win_d[i] = win_q[i];
            cnt_d[i] = cnt_q[i];
            if (tick_raw) begin
                win_d[i] = {win_q[i][DEPTH-2:0], s[i]};
                cnt_d[i] = cnt_q[i] + CW'(s[i]) - CW'(win_q[i][DEPTH-1]);
                if (cnt_d[i] >= HI_N) begin
                    out_d[i] = 1'b1;
                end else if (cnt_d[i] <= LO_N) begin
                    out_d[i] = 1'b0;
                end
            end
        end
    end

    // State registers; edge pulses are derived from the same edge that moves out.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q <= '0;
            for (int i = 0; i < CH; i++) begin
                win_q[i] <= '0;
                cnt_q[i] <= '0;
            end
            out_q  <= '0;
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
            for (int i = 0; i < CH; i++) begin
                win_q[i] <= win_d[i];
                cnt_q[i] <= cnt_d[i];
            end
            out_q  <= out_d;
            rise_q <= out_d & ~out_q;
            fall_q <= ~out_d & out_q;
        end
    end

    assign out  = out_q;
    assign rise = rise_q;
    assign fall = fall_q;

endmodule

// File: tb/tb_dfilter_mc.sv
// Directed self-checking bench for dfilter_mc (DIV=4, DEPTH=7, HI_TH=6,
// LO_TH=1, CH=4, synchronizer disabled). Cycle c counts from the first
// cycle with rst=0; ticks fall on c = 3, 7, 11, ...
module tb_dfilter_mc;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] indata;
    logic [3:0] out;
    logic [3:0] rise;
    logic [3:0] fall;
    logic       tick;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dfilter_mc #(
        .CH   (4),
        .DIV  (4),
        .DEPTH(7),
        .HI_TH(6),
        .LO_TH(1)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .indata(indata),
        .out   (out),
        .rise  (rise),
        .fall  (fall),
        .tick  (tick)
    );

    task automatic check(input string tag, input int cyc, input logic [3:0] obs, input logic [3:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cycle %0d: observed %b expected %b", tag, cyc, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] e_out;
        logic [3:0] e_rise;
        logic [3:0] e_fall;
        logic [3:0] e_tick;
        logic [3:0] d;

        rst    = 1'b1;
        indata = 4'b0000;

        // Reset held for three edges.
        for (int r = 0; r < 3; r++) begin
            step();
            check("rst_out",  r, out,  4'b0000);
            check("rst_rise", r, rise, 4'b0000);
            check("rst_fall", r, fall, 4'b0000);
            check("rst_tick", r, {3'b000, tick}, 4'b0000);
        end
        rst = 1'b0;

        // ch0: high until c=31, then low (rise at 24, fall on 6th zero tick -> 52)
        // ch1: single-cycle pulse at c=35, sampled by exactly one tick -> ignored
        // ch2: high until c=31, then alternates per tick -> holds 1
        // ch3: idle
        for (int c = 0; c < 72; c++) begin
            d[0] = (c < 31);
            d[1] = (c == 35);
            d[2] = (c < 31) ? 1'b1 : (((c - 31) / 4) % 2 == 1);
            d[3] = 1'b0;
            indata = d;

            e_tick = {3'b000, (c % 4 == 3)};
            e_out  = {1'b0, (c >= 24), 1'b0, (c >= 24 && c < 52)};
            e_rise = (c == 24) ? 4'b0101 : 4'b0000;
            e_fall = (c == 52) ? 4'b0001 : 4'b0000;

            check("tick", c, {3'b000, tick}, e_tick);
            check("out",  c, out,  e_out);
            check("rise", c, rise, e_rise);
            check("fall", c, fall, e_fall);
            step();
        end

        // Fill every channel, then reset mid-operation.
        indata = 4'b1111;
        for (int c = 72; c < 104; c++) begin
            step();
        end
        check("full_out",  104, out,  4'b1111);
        check("full_fall", 104, fall, 4'b0000);

        rst = 1'b1;
        step();
        check("mid_rst_out",  0, out,  4'b0000);
        check("mid_rst_rise", 0, rise, 4'b0000);
        check("mid_rst_fall", 0, fall, 4'b0000);
        check("mid_rst_tick", 0, {3'b000, tick}, 4'b0000);
        rst = 1'b0;

        // Refill from an empty window: prescaler restarts, out rises on the 6th tick.
        for (int c = 0; c < 28; c++) begin
            e_tick = {3'b000, (c % 4 == 3)};
            e_out  = (c >= 24) ? 4'b1111 : 4'b0000;
            e_rise = (c == 24) ? 4'b1111 : 4'b0000;

            check("refill_tick", c, {3'b000, tick}, e_tick);
            check("refill_out",  c, out,  e_out);
            check("refill_rise", c, rise, e_rise);
            check("refill_fall", c, fall, 4'b0000);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
